// File: rtl/raycast_pkg.sv
// Shared raycaster widths, projection constant, column FSM state and hit-side encodings.
// Pure definitions: no logic, no latency, no flow control.
package raycast_pkg;
   localparam int ANG_W      = 12;
   localparam int DIST_W     = 13;
   localparam int COS_FRAC   = 8;
   localparam int PROJ_CONST = 8896;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_ISSUE    = 4'd1,
      ST_WAIT_RSP = 4'd2,
      ST_SELECT   = 4'd3,
      ST_CORRECT  = 4'd4,
      ST_DIVIDE   = 4'd5,
      ST_EMIT     = 4'd6,
      ST_DONE     = 4'd7
   } col_state_e;

   localparam logic SIDE_H = 1'b0;
   localparam logic SIDE_V = 1'b1;
endpackage

// File: rtl/slice_restoring_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done is asserted on the Nth busy cycle.
// quotient is valid in the done cycle; start is ignored while busy.
module slice_restoring_divider #(
   parameter int N = 14,
   parameter int D = 13
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [D-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient
);
   localparam int CNT_W = $clog2(N + 1);

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [D-1:0]     rem_q, rem_d;
   logic [D-1:0]     div_q, div_d;
   logic [N-1:0]     quo_q, quo_d;
   logic [D:0]       trial;
   logic             ge;

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      div_d  = div_q;
      quo_d  = quo_q;
      // Remainder stays below the divisor, so the shifted trial fits in D+1 bits.
      trial  = {rem_q, quo_q[N-1]};
      ge     = (trial >= {1'b0, div_q});
      if (busy_q) begin
         rem_d = ge ? D'(trial - {1'b0, div_q}) : trial[D-1:0];
         quo_d = {quo_q[N-2:0], ge};
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
         end
      end else if (start) begin
         busy_d = 1'b1;
         cnt_d  = CNT_W'(N);
         rem_d  = '0;
         div_d  = divisor;
         quo_d  = dividend;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         div_q  <= '0;
         quo_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         div_q  <= div_d;
         quo_q  <= quo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = busy_q && (cnt_q == CNT_W'(1));
   assign quotient = quo_d;
endmodule

// File: rtl/slice_column_engine.sv
// Per-frame column sweep: ray request, nearest-hit select, fishbowl correction, divide to clamped slice height.
// 18 cycles per column plus response wait; ray request and slice output hold steady until their ready is seen.
module slice_column_engine
   import raycast_pkg::*;
#(
   parameter int NUM_COLS   = 160,
   parameter int COL_W      = 8,
   parameter int ANG_STEP   = 4,
   parameter int HEIGHT_W   = 7,
   parameter int MAX_HEIGHT = 120
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [ANG_W-1:0]    player_angle,
   output logic                busy,
   output logic                frame_done,
   output logic                ray_req_valid,
   input  logic                ray_req_ready,
   output logic [ANG_W-1:0]    ray_angle,
   input  logic                ray_rsp_valid,
   input  logic                ray_hit_h,
   input  logic [DIST_W-1:0]   ray_dist_h,
   input  logic                ray_hit_v,
   input  logic [DIST_W-1:0]   ray_dist_v,
   output logic [ANG_W-2:0]    cos_addr,
   input  logic [COS_FRAC:0]   cos_beta_data,
   output logic                slice_valid,
   input  logic                slice_ready,
   output logic [COL_W-1:0]    slice_col,
   output logic [HEIGHT_W-1:0] slice_height,
   output logic                slice_hit,
   output logic                slice_side
);
   localparam int Q_W    = $clog2(PROJ_CONST + 1);
   localparam int HALF   = NUM_COLS / 2;
   localparam int BETA_W = ANG_W - 1;
   localparam int PROD_W = DIST_W + COS_FRAC + 1;

   col_state_e          state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ANG_W-1:0]    pangle_q, pangle_d;
   logic                hit_h_q, hit_h_d, hit_v_q, hit_v_d;
   logic [DIST_W-1:0]   dist_h_q, dist_h_d, dist_v_q, dist_v_d;
   logic [DIST_W-1:0]   dist_q, dist_d;
   logic                hit_q, hit_d, side_q, side_d;
   logic [HEIGHT_W-1:0] height_q, height_d;

   logic [ANG_W-1:0]    alpha;
   logic [COL_W-1:0]    col_dist;
   logic [BETA_W-1:0]   beta_abs;
   logic [PROD_W-1:0]   prod, prod_sh;
   logic [DIST_W-1:0]   perp;
   logic                div_start, div_busy, div_done;
   logic [Q_W-1:0]      div_quo;

   always_comb begin
      // Modulo-2^ANG_W arithmetic wraps the ray angle naturally.
      alpha    = pangle_q + ANG_W'(HALF * ANG_STEP) - ANG_W'(col_q) * ANG_W'(ANG_STEP);
      col_dist = (col_q <= COL_W'(HALF)) ? COL_W'(HALF) - col_q : col_q - COL_W'(HALF);
      beta_abs = BETA_W'(col_dist) * BETA_W'(ANG_STEP);
      prod     = PROD_W'(dist_q) * PROD_W'(cos_beta_data);
      prod_sh  = prod >> COS_FRAC;
      perp     = (|prod_sh[PROD_W-1:DIST_W]) ? '1 : prod_sh[DIST_W-1:0];
      if (perp == '0) begin
         perp = DIST_W'(1);
      end
   end

   assign div_start = (state_q == ST_CORRECT) && !div_busy;

   slice_restoring_divider #(
      .N (Q_W),
      .D (DIST_W)
   ) u_div (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .dividend (Q_W'(PROJ_CONST)),
      .divisor  (perp),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      pangle_d = pangle_q;
      hit_h_d  = hit_h_q;
      hit_v_d  = hit_v_q;
      dist_h_d = dist_h_q;
      dist_v_d = dist_v_q;
      dist_d   = dist_q;
      hit_d    = hit_q;
      side_d   = side_q;
      height_d = height_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pangle_d = player_angle;
               col_d    = '0;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ray_req_ready) state_d = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            if (ray_rsp_valid) begin
               hit_h_d  = ray_hit_h;
               hit_v_d  = ray_hit_v;
               dist_h_d = ray_dist_h;
               dist_v_d = ray_dist_v;
               state_d  = ST_SELECT;
            end
         end
         ST_SELECT: begin
            // Equal distances resolve to the horizontal hit.
            if (hit_h_q && (!hit_v_q || dist_h_q <= dist_v_q)) begin
               dist_d  = dist_h_q;
               side_d  = SIDE_H;
               hit_d   = 1'b1;
               state_d = ST_CORRECT;
            end else if (hit_v_q) begin
               dist_d  = dist_v_q;
               side_d  = SIDE_V;
               hit_d   = 1'b1;
               state_d = ST_CORRECT;
            end else begin
               side_d   = SIDE_H;
               hit_d    = 1'b0;
               height_d = '0;
               state_d  = ST_EMIT;
            end
         end
         ST_CORRECT: state_d = ST_DIVIDE;
         ST_DIVIDE: begin
            if (div_done) begin
               height_d = (div_quo > Q_W'(MAX_HEIGHT)) ? HEIGHT_W'(MAX_HEIGHT)
                                                      : div_quo[HEIGHT_W-1:0];
               state_d  = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (slice_ready) begin
               if (col_q == COL_W'(NUM_COLS - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  col_d   = col_q + 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         col_q    <= '0;
         pangle_q <= '0;
         hit_h_q  <= 1'b0;
         hit_v_q  <= 1'b0;
         dist_h_q <= '0;
         dist_v_q <= '0;
         dist_q   <= '0;
         hit_q    <= 1'b0;
         side_q   <= 1'b0;
         height_q <= '0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         pangle_q <= pangle_d;
         hit_h_q  <= hit_h_d;
         hit_v_q  <= hit_v_d;
         dist_h_q <= dist_h_d;
         dist_v_q <= dist_v_d;
         dist_q   <= dist_d;
         hit_q    <= hit_d;
         side_q   <= side_d;
         height_q <= height_d;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign frame_done    = (state_q == ST_DONE);
   assign ray_req_valid = (state_q == ST_ISSUE);
   assign ray_angle     = ray_req_valid ? alpha : '0;
   assign cos_addr      = (state_q == ST_CORRECT) ? beta_abs : '0;
   assign slice_valid   = (state_q == ST_EMIT);
   assign slice_col     = col_q;
   assign slice_height  = height_q;
   assign slice_hit     = hit_q;
   assign slice_side    = side_q;
endmodule

// File: tb/tb_slice_column_engine.sv
// Directed bench for slice_column_engine: scripted intersection unit, cos ROM and renderer.
module tb_slice_column_engine;
   import raycast_pkg::*;
   localparam int NCOL = 160;

   logic        clock = 1'b0;
   logic        reset, start;
   logic [11:0] player_angle;
   logic        busy, frame_done, ray_req_valid, ray_req_ready;
   logic [11:0] ray_angle;
   logic        ray_rsp_valid, ray_hit_h, ray_hit_v;
   logic [12:0] ray_dist_h, ray_dist_v;
   logic [10:0] cos_addr;
   logic [8:0]  cos_beta_data;
   logic        slice_valid, slice_ready;
   logic [7:0]  slice_col;
   logic [6:0]  slice_height;
   logic        slice_hit, slice_side;

   int checks = 0;
   int errors = 0;

   logic        cfg_hh [NCOL];
   logic        cfg_hv [NCOL];
   logic [12:0] cfg_dh [NCOL];
   logic [12:0] cfg_dv [NCOL];
   int exp_h [NCOL];
   int exp_hit [NCOL];
   int exp_side [NCOL];
   int exp_ang [NCOL];
   int exp_lat [NCOL];
   int stall_col, req_stall_col, midstart_col, nextreq_col;

   always #5 clock = ~clock;

   slice_column_engine dut (
      .clock(clock), .reset(reset), .start(start), .player_angle(player_angle),
      .busy(busy), .frame_done(frame_done),
      .ray_req_valid(ray_req_valid), .ray_req_ready(ray_req_ready), .ray_angle(ray_angle),
      .ray_rsp_valid(ray_rsp_valid), .ray_hit_h(ray_hit_h), .ray_dist_h(ray_dist_h),
      .ray_hit_v(ray_hit_v), .ray_dist_v(ray_dist_v),
      .cos_addr(cos_addr), .cos_beta_data(cos_beta_data),
      .slice_valid(slice_valid), .slice_ready(slice_ready), .slice_col(slice_col),
      .slice_height(slice_height), .slice_hit(slice_hit), .slice_side(slice_side)
   );

   function automatic logic [8:0] cos_rom(input logic [10:0] a);
      case (a)
         11'd0, 11'd4: cos_rom = 9'd256;
         11'd320:      cos_rom = 9'd128;
         default:      cos_rom = 9'd200;
      endcase
   endfunction

   assign cos_beta_data = cos_rom(cos_addr);

   task automatic check_eq(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic clear_cfg();
      for (int i = 0; i < NCOL; i++) begin
         cfg_hh[i] = 1'b0; cfg_hv[i] = 1'b0; cfg_dh[i] = 13'd0; cfg_dv[i] = 13'd0;
         exp_h[i] = -1; exp_hit[i] = 0; exp_side[i] = 0; exp_ang[i] = -1; exp_lat[i] = -1;
      end
      stall_col = -1; req_stall_col = -1; midstart_col = -1; nextreq_col = -1;
   endtask

   task automatic do_col(input int c);
      int n;
      int lat;
      if (errors > 20) return;
      n = 0;
      while (!ray_req_valid && n < 100) begin @(negedge clock); n++; end
      if (!ray_req_valid) begin check_eq("req_timeout", ray_req_valid, 1); return; end
      if (exp_ang[c] >= 0) check_eq("ray_angle", ray_angle, exp_ang[c]);
      if (c == req_stall_col) begin
         ray_req_ready = 1'b0;
         repeat (3) @(negedge clock);
         check_eq("req_held_valid", ray_req_valid, 1);
         check_eq("req_held_angle", ray_angle, exp_ang[c]);
         ray_req_ready = 1'b1;
      end
      if (c == midstart_col) begin player_angle = 12'd0; start = 1'b1; end
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      ray_rsp_valid = 1'b1;
      ray_hit_h = cfg_hh[c]; ray_dist_h = cfg_dh[c];
      ray_hit_v = cfg_hv[c]; ray_dist_v = cfg_dv[c];
      @(negedge clock);
      ray_rsp_valid = 1'b0; ray_hit_h = 1'b0; ray_hit_v = 1'b0;
      lat = 1;
      while (!slice_valid && lat < 100) begin @(negedge clock); lat++; end
      if (!slice_valid) begin check_eq("slice_timeout", slice_valid, 1); return; end
      if (exp_lat[c] >= 0) check_eq("latency", lat, exp_lat[c]);
      if (exp_h[c] >= 0) begin
         check_eq("slice_col", slice_col, c);
         check_eq("slice_height", slice_height, exp_h[c]);
         check_eq("slice_hit", slice_hit, exp_hit[c]);
         check_eq("slice_side", slice_side, exp_side[c]);
      end
      if (c == stall_col) begin
         slice_ready = 1'b0;
         repeat (5) @(negedge clock);
         check_eq("stall_valid", slice_valid, 1);
         check_eq("stall_col", slice_col, c);
         check_eq("stall_height", slice_height, exp_h[c]);
         slice_ready = 1'b1;
      end
      @(negedge clock);
      if (c == nextreq_col) check_eq("next_req", ray_req_valid, 1);
   endtask

   task automatic run_frame(input logic [11:0] pa);
      @(negedge clock);
      player_angle = pa; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check_eq("frame_busy", busy, 1);
      for (int c = 0; c < NCOL; c++) do_col(c);
      check_eq("frame_done", frame_done, 1);
      @(negedge clock);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_done", frame_done, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; player_angle = 12'd0;
      ray_req_ready = 1'b1; slice_ready = 1'b1;
      ray_rsp_valid = 1'b0; ray_hit_h = 1'b0; ray_hit_v = 1'b0;
      ray_dist_h = 13'd0; ray_dist_v = 13'd0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_req", ray_req_valid, 0);
      check_eq("rst_slice_valid", slice_valid, 0);
      check_eq("rst_angle", ray_angle, 0);
      check_eq("rst_height", slice_height, 0);

      // Frame 1: basic hit, V-only with cos correction, no-hit timing, output stall.
      clear_cfg();
      cfg_hv[0] = 1'b1; cfg_dv[0] = 13'd200;
      exp_h[0] = 88; exp_hit[0] = 1; exp_side[0] = 1; exp_ang[0] = 320; exp_lat[0] = 17;
      exp_h[1] = 0; exp_hit[1] = 0; exp_side[1] = 0; exp_lat[1] = 2; nextreq_col = 1;
      cfg_hh[80] = 1'b1; cfg_dh[80] = 13'd128; cfg_dv[80] = 13'd5;
      exp_h[80] = 69; exp_hit[80] = 1; exp_side[80] = 0; exp_ang[80] = 0; exp_lat[80] = 17;
      stall_col = 80;
      exp_ang[159] = 3780;
      run_frame(12'd0);

      // Frame 2: selection rules, tie, zero distance, non-unity cos.
      clear_cfg();
      cfg_hh[79] = 1'b1; cfg_dh[79] = 13'd100; cfg_hv[79] = 1'b1; cfg_dv[79] = 13'd64;
      exp_h[79] = 120; exp_hit[79] = 1; exp_side[79] = 1;
      cfg_hh[80] = 1'b1; cfg_dh[80] = 13'd90; cfg_hv[80] = 1'b1; cfg_dv[80] = 13'd90;
      exp_h[80] = 98; exp_hit[80] = 1; exp_side[80] = 0;
      cfg_hh[81] = 1'b1; cfg_dh[81] = 13'd0;
      exp_h[81] = 120; exp_hit[81] = 1; exp_side[81] = 0;
      cfg_hh[82] = 1'b1; cfg_dh[82] = 13'd200; cfg_hv[82] = 1'b1; cfg_dv[82] = 13'd300;
      exp_h[82] = 57; exp_hit[82] = 1; exp_side[82] = 0;
      cfg_hh[83] = 1'b1; cfg_dh[83] = 13'd500; cfg_dv[83] = 13'd10;
      exp_h[83] = 22; exp_hit[83] = 1; exp_side[83] = 0;
      run_frame(12'd0);

      // Frame 3: angle wrap, start ignored while busy, request back-pressure.
      clear_cfg();
      exp_ang[0] = 314; exp_ang[80] = 4090; exp_ang[159] = 3774;
      midstart_col = 1; req_stall_col = 159;
      run_frame(12'd4090);

      // Reset while dividing, then a stray response in IDLE.
      @(negedge clock);
      player_angle = 12'd0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      ray_rsp_valid = 1'b1; ray_hit_h = 1'b1; ray_dist_h = 13'd100;
      @(negedge clock);
      ray_rsp_valid = 1'b0; ray_hit_h = 1'b0;
      @(negedge clock);
      check_eq("cos_addr_col0", cos_addr, 320);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_slice_valid", slice_valid, 0);
      check_eq("mid_rst_req", ray_req_valid, 0);
      check_eq("mid_rst_cos", cos_addr, 0);
      check_eq("mid_rst_hit", slice_hit, 0);
      check_eq("mid_rst_done", frame_done, 0);
      reset = 1'b0;
      ray_rsp_valid = 1'b1; ray_hit_h = 1'b1; ray_dist_h = 13'd50;
      @(negedge clock);
      ray_rsp_valid = 1'b0; ray_hit_h = 1'b0;
      repeat (20) @(negedge clock);
      check_eq("late_rsp_busy", busy, 0);
      check_eq("late_rsp_slice_valid", slice_valid, 0);
      check_eq("late_rsp_height", slice_height, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
